// File: rtl/fifo_wr_arb_pkg.sv
// Shared types and constants for the TX FIFO write-port scheduler.
// Covers the FSM state encoding, requester indices and frame lengths.
package fifo_wr_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND0 = 2'd1,
    SEND1 = 2'd2
  } state_e;

  typedef logic [1:0] req_idx_t;
  typedef logic [1:0] flen_t;

  localparam int       NUM_REQ  = 3;
  localparam req_idx_t REQ_REG  = 2'd0;
  localparam req_idx_t REQ_ALU  = 2'd1;
  localparam req_idx_t REQ_STAT = 2'd2;

  localparam flen_t FLEN_1B = 2'd1;
  localparam flen_t FLEN_2B = 2'd2;

  // Cyclic successor over the requester indices (STAT wraps back to REG).
  function automatic req_idx_t next_idx(input req_idx_t idx);
    return (idx == REQ_STAT) ? REQ_REG : req_idx_t'(idx + 2'd1);
  endfunction

endpackage

// File: rtl/fifo_wr_arb_if.sv
// Producer request/data/ack bundle plus the FIFO write-side signals.
// The master side drives the requests; the scheduler is the slave side.
interface fifo_wr_arb_if #(
  parameter int DATA_WD = 8
) ();

  logic                   reg_req;
  logic [DATA_WD-1:0]     reg_data;
  logic                   alu_req;
  logic [2*DATA_WD-1:0]   alu_data;
  logic                   stat_req;
  logic [DATA_WD-1:0]     stat_data;
  logic                   fifo_full;
  logic                   wr_inc;
  logic [DATA_WD-1:0]     fifo_wr_data;
  logic                   reg_ack;
  logic                   alu_ack;
  logic                   stat_ack;
  logic                   busy;

  modport master (
    output reg_req, reg_data, alu_req, alu_data, stat_req, stat_data, fifo_full,
    input  wr_inc, fifo_wr_data, reg_ack, alu_ack, stat_ack, busy
  );

  modport slave (
    input  reg_req, reg_data, alu_req, alu_data, stat_req, stat_data, fifo_full,
    output wr_inc, fifo_wr_data, reg_ack, alu_ack, stat_ack, busy
  );

endinterface

// File: rtl/fifo_wr_arb_rr_arb3.sv
// Three-way round-robin arbiter. Search starts after the last granted index.
// The last-grant pointer moves only when upd_en is high.
module rr_arb3
  import fifo_wr_arb_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               upd_en,
  output logic [NUM_REQ-1:0] gnt,
  output req_idx_t           gnt_idx
);

  req_idx_t last_q;
  req_idx_t cand;
  logic     found;

  always_comb begin
    gnt     = '0;
    gnt_idx = REQ_REG;
    cand    = last_q;
    found   = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = next_idx(cand);
      if (!found && req[cand]) begin
        found   = 1'b1;
        gnt_idx = cand;
      end
    end
    if (found) begin
      gnt[gnt_idx] = 1'b1;
    end
  end

  // Starting at STAT makes REG the first choice out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= REQ_STAT;
    end else if (upd_en) begin
      last_q <= gnt_idx;
    end
  end

endmodule

// File: rtl/fifo_wr_arb.sv
// Round-robin scheduler sharing the TX FIFO write port between the register,
// ALU (2 bytes, LSB first) and status producers, with FIFO_FULL backpressure.
module fifo_wr_arb
  import fifo_wr_arb_pkg::*;
#(
  parameter int DATA_WD = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  fifo_wr_arb_if.slave  bus
);

  state_e               state_q, state_d;
  logic [2*DATA_WD-1:0] hold_q, hold_d;
  req_idx_t             gidx_q;
  flen_t                flen_q;

  logic [NUM_REQ-1:0]   req_vec;
  logic [NUM_REQ-1:0]   gnt;
  req_idx_t             gnt_idx;
  logic                 upd_en;
  logic                 last_byte;

  assign req_vec = {bus.stat_req, bus.alu_req, bus.reg_req};
  assign upd_en  = (state_q == IDLE) && (|req_vec);

  rr_arb3 u_rr_arb3 (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req_vec),
    .upd_en  (upd_en),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  always_comb begin
    hold_d = '0;
    case (gnt_idx)
      REQ_REG:  hold_d = {{DATA_WD{1'b0}}, bus.reg_data};
      REQ_ALU:  hold_d = bus.alu_data;
      REQ_STAT: hold_d = {{DATA_WD{1'b0}}, bus.stat_data};
      default:  hold_d = '0;
    endcase
  end

  // The FSM only advances past a byte on a cycle where the FIFO accepts it.
  always_comb begin
    state_d          = state_q;
    bus.wr_inc       = 1'b0;
    bus.fifo_wr_data = '0;
    last_byte        = 1'b0;
    case (state_q)
      IDLE: begin
        if (upd_en) begin
          state_d = SEND0;
        end
      end
      SEND0: begin
        bus.fifo_wr_data = hold_q[DATA_WD-1:0];
        bus.wr_inc       = ~bus.fifo_full;
        if (!bus.fifo_full) begin
          if (flen_q == FLEN_2B) begin
            state_d = SEND1;
          end else begin
            last_byte = 1'b1;
            state_d   = IDLE;
          end
        end
      end
      SEND1: begin
        bus.fifo_wr_data = hold_q[2*DATA_WD-1:DATA_WD];
        bus.wr_inc       = ~bus.fifo_full;
        if (!bus.fifo_full) begin
          last_byte = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.reg_ack  = last_byte && (gidx_q == REQ_REG);
  assign bus.alu_ack  = last_byte && (gidx_q == REQ_ALU);
  assign bus.stat_ack = last_byte && (gidx_q == REQ_STAT);
  assign bus.busy     = (state_q != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      hold_q  <= '0;
      gidx_q  <= REQ_REG;
      flen_q  <= FLEN_1B;
    end else begin
      state_q <= state_d;
      if (upd_en) begin
        hold_q <= hold_d;
        gidx_q <= gnt_idx;
        flen_q <= (gnt_idx == REQ_ALU) ? FLEN_2B : FLEN_1B;
      end
    end
  end

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Directed bench for fifo_wr_arb: single frames, ALU stall, reset mid-frame,
// dropped request during a stall, and round-robin order with all requests held.
module tb_fifo_wr_arb;
  import fifo_wr_arb_pkg::*;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  fifo_wr_arb_if #(.DATA_WD(8)) bus ();

  fifo_wr_arb #(.DATA_WD(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs are driven here, checks follow #1 later.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic chk_out(input string tag, input logic busy, input logic wr, input logic [7:0] data,
                         input logic [2:0] acks);
    #1;
    chk({tag, ".busy"}, {15'd0, bus.busy}, {15'd0, busy});
    chk({tag, ".wr_inc"}, {15'd0, bus.wr_inc}, {15'd0, wr});
    chk({tag, ".data"}, {8'd0, bus.fifo_wr_data}, {8'd0, data});
    chk({tag, ".acks"}, {13'd0, bus.stat_ack, bus.alu_ack, bus.reg_ack}, {13'd0, acks});
  endtask

  logic       exp_busy [8];
  logic [7:0] exp_data [8];
  logic [2:0] exp_ack  [8];

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n         = 1'b0;
    bus.reg_req   = 1'b0;
    bus.reg_data  = '0;
    bus.alu_req   = 1'b0;
    bus.alu_data  = '0;
    bus.stat_req  = 1'b0;
    bus.stat_data = '0;
    bus.fifo_full = 1'b0;

    cyc();
    cyc();
    chk_out("reset", 1'b0, 1'b0, 8'h00, 3'b000);
    rst_n = 1'b1;

    // Single register byte
    cyc();
    bus.reg_req  = 1'b1;
    bus.reg_data = 8'hA5;
    chk_out("reg.idle", 1'b0, 1'b0, 8'h00, 3'b000);
    cyc();
    bus.reg_req = 1'b0;
    chk_out("reg.send", 1'b1, 1'b1, 8'hA5, 3'b001);
    cyc();
    chk_out("reg.done", 1'b0, 1'b0, 8'h00, 3'b000);

    // ALU frame, LSB first
    bus.alu_req  = 1'b1;
    bus.alu_data = 16'h1234;
    cyc();
    chk_out("alu.lsb", 1'b1, 1'b1, 8'h34, 3'b000);
    cyc();
    bus.alu_req = 1'b0;
    chk_out("alu.msb", 1'b1, 1'b1, 8'h12, 3'b010);
    cyc();
    chk_out("alu.done", 1'b0, 1'b0, 8'h00, 3'b000);

    // ALU frame stalled three cycles in SEND1
    bus.alu_req = 1'b1;
    cyc();
    chk_out("stall.lsb", 1'b1, 1'b1, 8'h34, 3'b000);
    cyc();
    bus.fifo_full = 1'b1;
    chk_out("stall.s1", 1'b1, 1'b0, 8'h12, 3'b000);
    cyc();
    chk_out("stall.s2", 1'b1, 1'b0, 8'h12, 3'b000);
    cyc();
    chk_out("stall.s3", 1'b1, 1'b0, 8'h12, 3'b000);
    bus.fifo_full = 1'b0;
    chk_out("stall.msb", 1'b1, 1'b1, 8'h12, 3'b010);
    cyc();
    bus.alu_req = 1'b0;
    chk_out("stall.done", 1'b0, 1'b0, 8'h00, 3'b000);

    // Reset asserted during SEND1, frame reissued from the LSB
    bus.alu_req  = 1'b1;
    bus.alu_data = 16'hBEEF;
    cyc();
    chk_out("rst.lsb", 1'b1, 1'b1, 8'hEF, 3'b000);
    cyc();
    chk_out("rst.msb", 1'b1, 1'b1, 8'hBE, 3'b010);
    rst_n = 1'b0;
    chk_out("rst.async", 1'b0, 1'b0, 8'h00, 3'b000);
    cyc();
    rst_n = 1'b1;
    chk_out("rst.rel", 1'b0, 1'b0, 8'h00, 3'b000);
    cyc();
    chk_out("rst.re_lsb", 1'b1, 1'b1, 8'hEF, 3'b000);
    cyc();
    bus.alu_req = 1'b0;
    chk_out("rst.re_msb", 1'b1, 1'b1, 8'hBE, 3'b010);
    cyc();
    chk_out("rst.done", 1'b0, 1'b0, 8'h00, 3'b000);

    // Status request pulsed while a register frame is stalled
    bus.reg_req   = 1'b1;
    bus.reg_data  = 8'h3C;
    bus.fifo_full = 1'b1;
    cyc();
    bus.stat_req  = 1'b1;
    bus.stat_data = 8'h77;
    chk_out("pulse.stall1", 1'b1, 1'b0, 8'h3C, 3'b000);
    cyc();
    bus.stat_req = 1'b0;
    chk_out("pulse.stall2", 1'b1, 1'b0, 8'h3C, 3'b000);
    bus.fifo_full = 1'b0;
    chk_out("pulse.write", 1'b1, 1'b1, 8'h3C, 3'b001);
    cyc();
    bus.reg_req = 1'b0;
    chk_out("pulse.idle1", 1'b0, 1'b0, 8'h00, 3'b000);
    cyc();
    chk_out("pulse.idle2", 1'b0, 1'b0, 8'h00, 3'b000);

    // All three held high from reset: REG, ALU, STAT, REG with one idle cycle between
    rst_n         = 1'b0;
    bus.reg_req   = 1'b1;
    bus.reg_data  = 8'h11;
    bus.alu_req   = 1'b1;
    bus.alu_data  = 16'h2233;
    bus.stat_req  = 1'b1;
    bus.stat_data = 8'h44;
    cyc();
    rst_n = 1'b1;
    chk_out("rr.rst", 1'b0, 1'b0, 8'h00, 3'b000);
    exp_busy = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    exp_data = '{8'h11, 8'h00, 8'h33, 8'h22, 8'h00, 8'h44, 8'h00, 8'h11};
    exp_ack  = '{3'b001, 3'b000, 3'b000, 3'b010, 3'b000, 3'b100, 3'b000, 3'b001};
    for (int k = 0; k < 8; k++) begin
      cyc();
      chk_out($sformatf("rr.c%0d", k), exp_busy[k], exp_busy[k], exp_data[k], exp_ack[k]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
